ps2_key_event_ctrl: RTL
=======================

PS2_KEY_EVENT_CTRL -- requirements
Module: ps2_key_event_ctrl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4: event queue depth, power of two, 2..16.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 2_000_000: idle cycles before a partial sequence is abandoned (20 ms at 100 MHz).
REQ-003 SHALL have parameters LANE0..LANE3, defaults 8'h23, 8'h2B, 8'h3B, 8'h42: non-extended scan codes tracked as lanes.
REQ-004 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: synchronous active-low reset.
REQ-006 SHALL have port byte_data, input, 8: latest received scan byte (scanner keycode[7:0]).
REQ-007 SHALL have port byte_valid, input, 1: one-cycle pulse marking byte_data valid (scanner oflag).
REQ-008 SHALL have port ev_valid, output, 1: event queue head valid.
REQ-009 SHALL have port ev_ready, input, 1: consumer accepts head when ev_valid && ev_ready.
REQ-010 SHALL have port ev_code, output, 8: head event scan code.
REQ-011 SHALL have port ev_ext, output, 1: head event carried an E0 prefix.
REQ-012 SHALL have port ev_break, output, 1: head event is a release (F0 prefix).
REQ-013 SHALL have port lane_down, output, 4: live pressed state of LANE0..LANE3.
REQ-014 SHALL have port overflow, output, 1: sticky, an event was dropped due to a full queue.
REQ-015 SHALL have port seq_err, output, 1: one-cycle pulse on timeout abort.

Function
REQ-016 SHALL implement parser FSM states IDLE, EXT, BRK, EXT_BRK; state changes only on byte_valid or timeout.
REQ-017 In IDLE: E0->EXT; F0->BRK; other code->emit {code, ext=0, brk=0}, stay IDLE.
REQ-018 In EXT: F0->EXT_BRK; code->emit {code, ext=1, brk=0}, ->IDLE.
REQ-019 In BRK: code->emit {code, ext=0, brk=1}, ->IDLE; in EXT_BRK: code->emit {code, ext=1, brk=1}, ->IDLE.
REQ-020 Bytes 00, AA, E1, FA, FC, FE, FF SHALL be discarded in any state, FSM->IDLE, no event emitted.
REQ-021 E0 received in EXT or EXT_BRK, or F0 in BRK or EXT_BRK, SHALL be ignored with state held.
REQ-022 Timeout counter SHALL clear on every byte_valid and count while state != IDLE; at TIMEOUT_CYCLES-1 the FSM SHALL return to IDLE and pulse seq_err for one cycle.
REQ-023 A non-extended make of LANEn SHALL set lane_down[n]; a non-extended break SHALL clear it; extended codes never affect lanes.
REQ-024 A make of LANEn while lane_down[n]=1 (typematic repeat) SHALL NOT be enqueued; lane_down is unchanged.
REQ-025 Latency: byte_valid at cycle N SHALL produce ev_valid, head fields and lane_down update visible at cycle N+1 when the queue was empty.
REQ-026 Queue SHALL be FIFO, show-ahead; head fields stable while ev_valid && !ev_ready.
REQ-027 Push when full without simultaneous pop SHALL drop the new event and set overflow; lane_down still updates.
REQ-028 Simultaneous push and pop when full SHALL succeed, with no overflow.
REQ-029 Pop when empty SHALL be ignored; ev_valid=0 when empty, with ev_code/ev_ext/ev_break don't-care.
REQ-030 Pointers SHALL wrap modulo FIFO_DEPTH; occupancy counter SHALL be width clog2(FIFO_DEPTH)+1.

Reset
REQ-031 When rst_n=0 at a clk edge: FSM->IDLE, timeout counter=0, queue empty, ev_valid=0, lane_down=0, overflow=0, seq_err=0, ev_code/ev_ext/ev_break=0.
REQ-032 Reset asserted mid-sequence (e.g. after E0) SHALL discard the partial sequence; byte_valid during reset SHALL be ignored.
REQ-033 overflow SHALL clear only on reset.

Verification
REQ-034 Bytes 23; 2B, with ev_ready=1 -> events {23,0,0}, {2B,0,0}; lane_down=4'b0011.
REQ-035 Bytes E0 F0 75 -> single event {75,1,1}; lane_down unchanged; FSM back in IDLE.
REQ-036 Bytes 3B, 3B, 3B, F0 3B -> exactly two events, {3B,0,0} and {3B,0,1}; lane_down[2] is 1 then 0.
REQ-037 ev_ready=0; six makes of distinct non-lane codes -> first four are queued in order, overflow=1; the last two are lost.
REQ-038 Byte E0, then no bytes for TIMEOUT_CYCLES (set to 100) -> seq_err pulse at the 100th idle cycle; a subsequent 1C yields {1C,0,0}.
REQ-039 Bytes F0, then rst_n=0 for 1 cycle, then 42 -> event {42,0,0} (make, not break); lane_down[3]=1.

Source files
------------

// File: rtl/ps2_key_event_ctrl.sv
// PS/2 scan-byte parser with lane tracking and a show-ahead event queue.
// Bytes arrive as one-cycle pulses; completed make/break codes become events
// {code, ext, brk} that a consumer drains with a valid/ready handshake.
module ps2_key_event_ctrl #(
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 2_000_000,
    parameter logic [7:0]  LANE0          = 8'h23,
    parameter logic [7:0]  LANE1          = 8'h2B,
    parameter logic [7:0]  LANE2          = 8'h3B,
    parameter logic [7:0]  LANE3          = 8'h42
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] byte_data,
    input  logic       byte_valid,
    output logic       ev_valid,
    input  logic       ev_ready,
    output logic [7:0] ev_code,
    output logic       ev_ext,
    output logic       ev_break,
    output logic [3:0] lane_down,
    output logic       overflow,
    output logic       seq_err
);

    localparam int unsigned AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNTW = AW + 1;
    localparam int unsigned CW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [CW-1:0]   TO_LAST  = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CNTW-1:0] CNT_FULL = CNTW'(FIFO_DEPTH);
    localparam logic [7:0]      LANE_CODES [4] = '{LANE0, LANE1, LANE2, LANE3};

    typedef enum logic [1:0] {
        StIdle,
        StExt,
        StBrk,
        StExtBrk
    } state_e;

    // Parser state
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          seq_err_q, seq_err_d;
    logic [3:0]    lane_q, lane_d;

    // Queue state; entries are {ext, brk, code}
    logic [9:0]      mem_q [FIFO_DEPTH];
    logic [9:0]      mem_d [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0] count_q, count_d;
    logic            overflow_q, overflow_d;

    // Parser -> queue handshake
    logic push;
    logic push_ext;
    logic push_brk;
    logic pop;
    logic full;
    logic wr_en;

    // Bytes that are protocol chatter (ACK, BAT, errors, Pause prefix) and never form an event
    function automatic logic is_discard(input logic [7:0] b);
        logic r;
        case (b)
            8'h00, 8'hAA, 8'hE1, 8'hFA, 8'hFC, 8'hFE, 8'hFF: r = 1'b1;
            default:                                         r = 1'b0;
        endcase
        return r;
    endfunction

    // Parser next state, timeout, lane tracking and event generation
    always_comb begin
        logic suppress;
        state_d   = state_q;
        cnt_d     = cnt_q;
        seq_err_d = 1'b0;
        lane_d    = lane_q;
        push      = 1'b0;
        push_ext  = 1'b0;
        push_brk  = 1'b0;
        suppress  = 1'b0;

        if (byte_valid) begin
            cnt_d = '0;
            if (is_discard(byte_data)) begin
                state_d = StIdle;
            end else if (byte_data == 8'hE0) begin
                // A repeated E0 is ignored; E0 after F0 folds into the combined prefix
                if (state_q == StIdle) begin
                    state_d = StExt;
                end else if (state_q == StBrk) begin
                    state_d = StExtBrk;
                end
            end else if (byte_data == 8'hF0) begin
                if (state_q == StIdle) begin
                    state_d = StBrk;
                end else if (state_q == StExt) begin
                    state_d = StExtBrk;
                end
            end else begin
                push_ext = (state_q == StExt) || (state_q == StExtBrk);
                push_brk = (state_q == StBrk) || (state_q == StExtBrk);
                state_d  = StIdle;
                if (!push_ext) begin
                    for (int i = 0; i < 4; i++) begin
                        if (byte_data == LANE_CODES[i]) begin
                            if (push_brk) begin
                                lane_d[i] = 1'b0;
                            end else if (lane_q[i]) begin
                                // Typematic repeat of a held lane key
                                suppress = 1'b1;
                            end else begin
                                lane_d[i] = 1'b1;
                            end
                        end
                    end
                end
                push = !suppress;
            end
        end else if (state_q != StIdle) begin
            if (cnt_q == TO_LAST) begin
                state_d   = StIdle;
                seq_err_d = 1'b1;
                cnt_d     = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    assign pop   = (count_q != '0) && ev_ready;
    assign full  = (count_q == CNT_FULL);
    // A full queue still accepts a push when the head leaves in the same cycle
    assign wr_en = push && (!full || pop);

    // Queue next state: pointers, occupancy, storage and sticky overflow
    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | (push && full && !pop);

        if (wr_en) begin
            mem_d[wr_ptr_q] = {push_ext, push_brk, byte_data};
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        unique case ({wr_en, pop})
            2'b10:   count_d = count_q + CNTW'(1);
            2'b01:   count_d = count_q - CNTW'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            seq_err_q  <= 1'b0;
            lane_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            seq_err_q  <= seq_err_d;
            lane_q     <= lane_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            mem_q      <= mem_d;
        end
    end

    assign ev_valid  = (count_q != '0);
    assign ev_code   = mem_q[rd_ptr_q][7:0];
    assign ev_break  = mem_q[rd_ptr_q][8];
    assign ev_ext    = mem_q[rd_ptr_q][9];
    assign lane_down = lane_q;
    assign overflow  = overflow_q;
    assign seq_err   = seq_err_q;

endmodule
